// File: rtl/ins_fetcher.sv
// Instruction fetch stage: one outstanding I-cache request, predictor hookup and a small
// circular instruction queue. Define IF_PREDICT_EN to follow the branch predictor.
module ins_fetcher #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int unsigned IQ_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rdy_i,
    output logic        icache_req_valid_o,
    output logic [31:0] icache_req_addr_o,
    input  logic        icache_resp_valid_i,
    input  logic [31:0] icache_resp_ins_i,
    output logic [31:0] pc_cur_o,
    output logic [31:0] ins_cur_o,
    input  logic [31:0] pc_pred_i,
    input  logic        predict_jump_i,
    output logic        iq_valid_o,
    output logic [31:0] iq_ins_o,
    output logic [31:0] iq_pc_o,
    output logic        iq_pred_jump_o,
    input  logic        iq_ready_i,
    input  logic        rob_flush_i,
    input  logic [31:0] rob_target_pc_i
);

    localparam int unsigned PW = $clog2(IQ_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DepthCnt = CW'(IQ_DEPTH);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StWait    = 2'd1;
    localparam logic [1:0] StDiscard = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   addr_q, addr_d;
    logic          req_q, req_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] wptr_q, wptr_d;

    logic [31:0] ins_mem [IQ_DEPTH];
    logic [31:0] pc_mem  [IQ_DEPTH];
    logic        pred_mem[IQ_DEPTH];

    logic        push, pop;
    logic [31:0] next_pc;
    logic        pred_bit;

`ifdef IF_PREDICT_EN
    assign next_pc  = pc_pred_i;
    assign pred_bit = predict_jump_i;
`else
    assign next_pc  = pc_q + 32'd4;
    assign pred_bit = 1'b0;
`endif

    assign iq_valid_o = (count_q != '0);
    assign pop        = iq_valid_o && iq_ready_i;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        req_d   = req_q;
        count_d = count_q;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        push    = 1'b0;
        if (rdy_i) begin
            if (rob_flush_i) begin
                count_d = '0;
                rptr_d  = '0;
                wptr_d  = '0;
                pc_d    = rob_target_pc_i;
                // An outstanding request is kept alive until its response can be dropped.
                if (state_q != StIdle) begin
                    if (icache_resp_valid_i) begin
                        state_d = StIdle;
                        req_d   = 1'b0;
                    end else begin
                        state_d = StDiscard;
                    end
                end
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (count_q < DepthCnt) begin
                            req_d   = 1'b1;
                            addr_d  = pc_q;
                            state_d = StWait;
                        end
                    end
                    StWait: begin
                        if (icache_resp_valid_i) begin
                            push    = 1'b1;
                            pc_d    = next_pc;
                            req_d   = 1'b0;
                            state_d = StIdle;
                        end
                    end
                    StDiscard: begin
                        if (icache_resp_valid_i) begin
                            req_d   = 1'b0;
                            state_d = StIdle;
                        end
                    end
                    default: begin
                        req_d   = 1'b0;
                        state_d = StIdle;
                    end
                endcase
                if (push) wptr_d = wptr_q + 1'b1;
                if (pop) rptr_d = rptr_q + 1'b1;
                count_d = count_q + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
            count_q <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            count_q <= count_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
        end
    end

    // Storage needs no reset: outputs are masked while the queue is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            ins_mem[wptr_q]  <= icache_resp_ins_i;
            pc_mem[wptr_q]   <= pc_q;
            pred_mem[wptr_q] <= pred_bit;
        end
    end

    assign icache_req_valid_o = req_q;
    // Latched at issue so the address stays stable even if a flush redirects pc mid-request.
    assign icache_req_addr_o  = addr_q;
    assign pc_cur_o           = pc_q;
    assign ins_cur_o          = icache_resp_ins_i;
    assign iq_ins_o           = iq_valid_o ? ins_mem[rptr_q] : 32'h0;
    assign iq_pc_o            = iq_valid_o ? pc_mem[rptr_q] : 32'h0;
    assign iq_pred_jump_o     = iq_valid_o ? pred_mem[rptr_q] : 1'b0;

endmodule

// File: tb/tb_ins_fetcher.sv
// Bench for ins_fetcher: directed test-plan steps then random traffic, all checked
// against a queue-based transaction model of the fetch stage.
module tb_ins_fetcher;

    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int unsigned IQ_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b1;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_ins = 32'h0;
    logic [31:0] pc_cur, ins_cur;
    logic [31:0] pc_pred = 32'h0;
    logic        predict_jump = 1'b0;
    logic        iq_valid;
    logic [31:0] iq_ins, iq_pc;
    logic        iq_pred_jump;
    logic        iq_ready = 1'b0;
    logic        rob_flush = 1'b0;
    logic [31:0] rob_target_pc = 32'h0;

    ins_fetcher #(.RESET_PC(RESET_PC), .IQ_DEPTH(IQ_DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n), .rdy_i(rdy),
        .icache_req_valid_o(req_valid), .icache_req_addr_o(req_addr),
        .icache_resp_valid_i(resp_valid), .icache_resp_ins_i(resp_ins),
        .pc_cur_o(pc_cur), .ins_cur_o(ins_cur),
        .pc_pred_i(pc_pred), .predict_jump_i(predict_jump),
        .iq_valid_o(iq_valid), .iq_ins_o(iq_ins), .iq_pc_o(iq_pc),
        .iq_pred_jump_o(iq_pred_jump), .iq_ready_i(iq_ready),
        .rob_flush_i(rob_flush), .rob_target_pc_i(rob_target_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        pred;
    } entry_t;

    // Transaction model: fetch pc, one outstanding request, discard-pending flag, FIFO.
    entry_t      m_q[$];
    logic [31:0] m_pc = RESET_PC;
    logic [31:0] m_addr = RESET_PC;
    bit          m_req = 0;
    bit          m_disc = 0;
    int          wait_cyc = 0;
    int          lat = 2;
    bit          force_pred = 0;
    logic [31:0] forced_pc = 32'h0;
    int          compared = 0;
    int          mismatched = 0;
`ifdef IF_PREDICT_EN
    localparam bit PredEn = 1'b1;
`else
    localparam bit PredEn = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        entry_t h;
        h = (m_q.size() > 0) ? m_q[0] : '0;
        chk("req_valid", {31'd0, req_valid}, {31'd0, m_req});
        chk("req_addr", req_addr, m_addr);
        chk("pc_cur", pc_cur, m_pc);
        chk("ins_cur", ins_cur, resp_ins);
        chk("iq_valid", {31'd0, iq_valid}, {31'd0, m_q.size() > 0});
        chk("iq_ins", iq_ins, h.ins);
        chk("iq_pc", iq_pc, h.pc);
        chk("iq_pred", {31'd0, iq_pred_jump}, {31'd0, h.pred});
    endtask

    task automatic tick();
        logic [31:0] r, nxt;
        logic        pb;
        bit          resp, pop_ok;
        int          sz;
        resp_valid = m_req && (wait_cyc >= lat);
        if (rob_flush && m_disc && resp_valid) resp_valid = 1'b0;
        resp_ins = $urandom;
        if (force_pred) begin
            pc_pred      = forced_pc;
            predict_jump = 1'b1;
        end else begin
            r            = $urandom;
            pc_pred      = r[0] ? (m_pc + 32'd4) : {r[31:2], 2'b00};
            predict_jump = r[1];
        end
        @(posedge clk);
        nxt = PredEn ? pc_pred : m_pc + 32'd4;
        pb  = PredEn ? predict_jump : 1'b0;
        if (rdy) begin
            sz   = m_q.size();
            resp = resp_valid && m_req;
            if (rob_flush) begin
                m_q.delete();
                m_pc = rob_target_pc;
                if (m_req) begin
                    if (resp) begin
                        m_req  = 0;
                        m_disc = 0;
                    end else begin
                        m_disc = 1;
                    end
                end
            end else begin
                pop_ok = (sz > 0) && iq_ready;
                if (m_req) begin
                    if (resp) begin
                        if (!m_disc) begin
                            m_q.push_back('{ins: resp_ins, pc: m_pc, pred: pb});
                            m_pc = nxt;
                        end
                        m_req  = 0;
                        m_disc = 0;
                    end
                end else if (sz < IQ_DEPTH) begin
                    m_req  = 1;
                    m_addr = m_pc;
                end
                if (pop_ok) void'(m_q.pop_front());
            end
        end
        wait_cyc = m_req ? wait_cyc + 1 : 0;
        #1;
        check_all();
    endtask

    initial begin
        logic [31:0] held;
        logic [31:0] rnd;
        #12;
        chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
        chk("rst_iq_valid", {31'd0, iq_valid}, 32'd0);
        chk("rst_pc_cur", pc_cur, RESET_PC);
        chk("rst_iq_pc", iq_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch, latency 2, dispatcher always ready.
        lat      = 2;
        iq_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 20 && !req_valid; i++) tick();
            chk("seq_req_addr", req_addr, 32'(4 * k));
            for (int i = 0; i < 20 && req_valid; i++) tick();
        end

        // Queue fills to depth and then stops requesting; one pop frees one request.
        iq_ready = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        chk("full_no_req", {31'd0, req_valid}, 32'd0);
        chk("full_iq_valid", {31'd0, iq_valid}, 32'd1);
        iq_ready = 1'b1;
        tick();
        iq_ready = 1'b0;
        tick();
        chk("pop_then_req", {31'd0, req_valid}, 32'd1);

        // Flush mid-WAIT; the response arrives 3 cycles later and is dropped.
        iq_ready = 1'b1;
        lat      = 4;
        for (int i = 0; i < 40 && !(m_req && !m_disc && wait_cyc == 1); i++) tick();
        rob_flush     = 1'b1;
        rob_target_pc = 32'h100;
        tick();
        rob_flush = 1'b0;
        chk("flw_iq_valid", {31'd0, iq_valid}, 32'd0);
        chk("flw_req_held", {31'd0, req_valid}, 32'd1);
        for (int i = 0; i < 20 && req_valid; i++) tick();
        chk("flw_dropped", {31'd0, iq_valid}, 32'd0);
        tick();
        chk("flw_redirect_req", {31'd0, req_valid}, 32'd1);
        chk("flw_redirect_addr", req_addr, 32'h100);

        // Flush coincident with the response.
        lat = 2;
        for (int i = 0; i < 40 && !(m_req && !m_disc && wait_cyc >= lat); i++) tick();
        rob_flush     = 1'b1;
        rob_target_pc = 32'h100;
        tick();
        rob_flush = 1'b0;
        chk("flr_req_drop", {31'd0, req_valid}, 32'd0);
        chk("flr_iq_valid", {31'd0, iq_valid}, 32'd0);
        tick();
        chk("flr_req", {31'd0, req_valid}, 32'd1);
        chk("flr_addr", req_addr, 32'h100);

        // Predictor redirect from 0x20 to 0x80.
        iq_ready = 1'b0;
        for (int i = 0; i < 40 && m_req; i++) tick();
        rob_flush     = 1'b1;
        rob_target_pc = 32'h20;
        tick();
        rob_flush  = 1'b0;
        force_pred = 1;
        forced_pc  = 32'h80;
        for (int i = 0; i < 20 && !req_valid; i++) tick();
        chk("pred_req_addr", req_addr, 32'h20);
        for (int i = 0; i < 20 && req_valid; i++) tick();
        chk("pred_iq_pc", iq_pc, 32'h20);
        chk("pred_iq_bit", {31'd0, iq_pred_jump}, {31'd0, PredEn});
        for (int i = 0; i < 20 && !req_valid; i++) tick();
        chk("pred_next_addr", req_addr, PredEn ? 32'h80 : 32'h24);
        force_pred = 0;

        // rdy low for 5 cycles in WAIT with dispatcher ready.
        iq_ready = 1'b1;
        lat      = 3;
        for (int i = 0; i < 40 && !(m_req && !m_disc && wait_cyc == 1); i++) tick();
        held = req_addr;
        rdy  = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("rdy_req_held", {31'd0, req_valid}, 32'd1);
        chk("rdy_addr_held", req_addr, held);
        rdy = 1'b1;
        for (int i = 0; i < 20; i++) tick();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            rnd           = $urandom;
            rdy           = (rnd[3:0] != 4'd0);
            iq_ready      = (rnd[6:4] < 3'd5);
            rob_flush     = (rnd[11:7] == 5'd0);
            rob_target_pc = {rnd[31:14], 2'b00} ^ 32'h0000_1000;
            if (!m_req) lat = $urandom_range(1, 4);
            tick();
        end
        rob_flush = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
